// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point datapath (divider and multiplier).
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RND,
    DONE
  } fp_state_e;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  // Bit positions inside the 4-bit flags vector {invalid, div_by_zero, overflow, underflow}
  localparam int FLAG_INVALID     = 3;
  localparam int FLAG_DIV_BY_ZERO = 2;
  localparam int FLAG_OVERFLOW    = 1;
  localparam int FLAG_UNDERFLOW   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_div_iter_classify.sv
// Operand classifier: splits an IEEE-style word into fields and tags it.
// Subnormals are flushed to zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] op_i,
  output fp_class_e             cls_o,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [FRAC_W:0]       mant_o
);

  logic [FRAC_W-1:0] frac;

  assign sign_o = op_i[EXP_W+FRAC_W];
  assign exp_o  = op_i[EXP_W+FRAC_W-1:FRAC_W];
  assign frac   = op_i[FRAC_W-1:0];
  assign mant_o = {1'b1, frac};

  // Tag the operand from its exponent/fraction pattern
  always_comb begin
    cls_o = NORM;
    if (exp_o == '0) begin
      cls_o = ZERO;
    end else if (&exp_o) begin
      cls_o = (frac == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative floating-point divider: one restoring quotient bit per cycle,
// round-to-nearest-even, flush-to-zero on subnormal inputs and results.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int  EXP_W  = 8,
  parameter int  FRAC_W = 23,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [3:0]   flags
);

  localparam int QW    = FRAC_W + 4;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(FRAC_W + 4);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAC_W + 3);
  localparam logic signed [EW-1:0] BIAS_E   = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] MAX_E    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_E    = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E   = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  fp_class_e         cls_a, cls_b;
  logic              sgn_a, sgn_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W:0]   mant_a, mant_b;

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
    .op_i(a), .cls_o(cls_a), .sign_o(sgn_a), .exp_o(exp_a), .mant_o(mant_a)
  );

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
    .op_i(b), .cls_o(cls_b), .sign_o(sgn_b), .exp_o(exp_b), .mant_o(mant_b)
  );

  fp_state_e          state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic [FRAC_W:0]    mb_q, mb_d;
  logic [FRAC_W+1:0]  rem_q, rem_d;
  logic [QW-1:0]      q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       quot_q, quot_d;
  logic [3:0]         flags_q, flags_d;

  logic                   ge;
  logic [FRAC_W:0]        trial;
  logic signed [EW-1:0]   e_base, e_adj, e_fin;
  logic [FRAC_W-1:0]      frac_t, frac_r;
  logic [FRAC_W:0]        frac_sum;
  logic                   guard, sticky, round_up;
  logic [W-1:0]           rnd_result;
  logic [3:0]             rnd_flags;

  // Normalise the raw quotient, round to nearest even and range-check the exponent
  always_comb begin
    e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_E;
    if (q_q[QW-1]) begin
      frac_t = q_q[QW-2:3];
      guard  = q_q[2];
      sticky = (|q_q[1:0]) | (|rem_q);
      e_adj  = e_base;
    end else begin
      frac_t = q_q[QW-3:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|rem_q);
      e_adj  = e_base - ONE_E;
    end
    round_up = guard & (sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + (FRAC_W+1)'(round_up);
    frac_r   = frac_sum[FRAC_W-1:0];
    e_fin    = frac_sum[FRAC_W] ? e_adj + ONE_E : e_adj;
    rnd_result = {sign_q, e_fin[EXP_W-1:0], frac_r};
    rnd_flags  = '0;
    if (e_fin >= MAX_E) begin
      rnd_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_fin <= ZERO_E) begin
      rnd_result = {sign_q, {(W-1){1'b0}}};
      rnd_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  // Next-state logic: accept/special-case decode, restoring iteration, result hand-off
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    flags_d = flags_q;

    // Remainder stays below 2*mb, so the difference always fits FRAC_W+1 bits when taken
    ge    = rem_q >= {1'b0, mb_q};
    trial = rem_q[FRAC_W:0] - mb_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sgn_a ^ sgn_b;
          ea_d    = exp_a;
          eb_d    = exp_b;
          mb_d    = mant_b;
          rem_d   = {1'b0, mant_a};
          q_d     = '0;
          cnt_d   = '0;
          flags_d = '0;
          state_d = DONE;
          if (cls_a == NAN || cls_b == NAN) begin
            quot_d = QNAN;
          end else if ((cls_a == INF && cls_b == INF) || (cls_a == ZERO && cls_b == ZERO)) begin
            quot_d = QNAN;
            flags_d[FLAG_INVALID] = 1'b1;
          end else if (cls_a == INF) begin
            quot_d = {sgn_a ^ sgn_b, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          end else if (cls_b == INF) begin
            quot_d = {sgn_a ^ sgn_b, {(W-1){1'b0}}};
          end else if (cls_b == ZERO) begin
            quot_d = {sgn_a ^ sgn_b, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_d[FLAG_DIV_BY_ZERO] = 1'b1;
          end else if (cls_a == ZERO) begin
            quot_d = {sgn_a ^ sgn_b, {(W-1){1'b0}}};
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        q_d   = {q_q[QW-2:0], ge};
        rem_d = ge ? {trial, 1'b0} : {rem_q[FRAC_W:0], 1'b0};
        if (cnt_q == CNT_LAST) begin
          state_d = RND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RND: begin
        quot_d  = rnd_result;
        flags_d = rnd_flags;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: driver pushes expected results, monitor pops on handshake.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid;
  logic [31:0] quotient;
  logic [3:0]  flags;

  int          total = 0;
  int          bad = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  bit          ready_mode = 1'b0;
  logic        ready_val = 1'b0;

  fp_div_iter #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .flags(flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got q=%h f=%b required none", quotient, flags);
      end else begin
        mon_e = exp_q.pop_front();
        if ({flags, quotient} !== mon_e) begin
          bad++;
          $display("FAIL result got q=%h f=%b required q=%h f=%b",
                   quotient, flags, mon_e[31:0], mon_e[35:32]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    bit zx, zy, ix, iy, nx, ny, g, st;
    longint unsigned num, den, qq, rr, mant;
    int e;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 8'hFF) && (fx == 0); iy = (ey == 8'hFF) && (fy == 0);
    nx = (ex == 8'hFF) && (fx != 0); ny = (ey == 8'hFF) && (fy != 0);
    if (nx || ny) return {4'b0000, 32'h7FC00000};
    if ((ix && iy) || (zx && zy)) return {4'b1000, 32'h7FC00000};
    if (ix) return {4'b0000, s, 8'hFF, 23'h0};
    if (iy) return {4'b0000, s, 31'h0};
    if (zy) return {4'b0100, s, 8'hFF, 23'h0};
    if (zx) return {4'b0000, s, 31'h0};
    num = {40'h0, 1'b1, fx} << 40;
    den = {40'h0, 1'b1, fy};
    qq = num / den;
    rr = num % den;
    e = int'(ex) - int'(ey) + 127;
    if (qq >= (64'd1 << 40)) begin
      mant = qq >> 17; g = qq[16]; st = (qq[15:0] != 0);
    end else begin
      mant = qq >> 16; g = qq[15]; st = (qq[14:0] != 0);
      e = e - 1;
    end
    st = st || (rr != 0);
    if (g && (st || mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0001, s, 31'h0};
    return {4'b0000, s, e[7:0], mant[22:0]};
  endfunction

  // Offer operands until accepted; on return the accept edge has just passed (+1)
  task automatic send(input logic [31:0] ta, input logic [31:0] tv, input logic [35:0] e,
                      input bit push, output bit ok);
    ok = 1'b0;
    a = ta; b = tv; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (push) exp_q.push_back(e);
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++; bad++;
      $display("FAIL accept_timeout got in_ready=0 required 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tv, input logic [31:0] eq,
                        input logic [3:0] ef, input int lat);
    bit ok;
    int k;
    ready_val = 1'b0;
    send(ta, tv, {ef, eq}, 1'b1, ok);
    if (ok) begin
      k = 0;
      while (!out_valid && k < 100) begin
        @(posedge clk); #1; k++;
      end
      chk("latency", 64'(k), 64'(lat));
      ready_val = 1'b1;
      wait_drain();
    end
  endtask

  logic [31:0] dv_a [15] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                             32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'h7FC00000, 32'h7F800000,
                             32'h3F800000, 32'h80000000, 32'hC0000000, 32'h00400000, 32'h3F800000};
  logic [31:0] dv_b [15] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
                             32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F800000, 32'hFF800000,
                             32'hFF800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00400000};
  logic [31:0] dv_q [15] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h7F800000, 32'h7FC00000,
                             32'hFF800000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                             32'h80000000, 32'h80000000, 32'hC0000000, 32'h00000000, 32'h7F800000};
  logic [3:0]  dv_f [15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000,
                             4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b1000,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
  int          dv_l [15] = '{28, 28, 28, 0, 0, 0, 28, 28, 0, 0, 0, 0, 28, 0, 0};

  initial begin
    bit ok;
    logic [31:0] ra, rb;
    logic [35:0] r;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_op(dv_a[i], dv_b[i], dv_q[i], dv_f[i], dv_l[i]);

    // Backpressure: result must hold in DONE while the consumer stalls
    ready_val = 1'b0;
    send(32'h40C00000, 32'h40000000, {4'b0000, 32'h40400000}, 1'b1, ok);
    for (int k = 0; k < 100 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_quotient", 64'(quotient), 64'h40400000);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    ready_val = 1'b1;
    wait_drain();

    // Asynchronous reset in the middle of an iteration
    send(32'h40C00000, 32'h40000000, 36'h0, 1'b0, ok);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_flags", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);

    // Back-to-back normal operands with random gaps and random consumer stalls
    ready_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ra = {1'($urandom_range(0, 1)),
            (i % 4 == 3) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154)),
            23'($urandom)};
      rb = {1'($urandom_range(0, 1)),
            (i % 4 == 3) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154)),
            23'($urandom)};
      r = model(ra, rb);
      send(ra, rb, r, 1'b1, ok);
    end
    wait_drain();
    ready_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog got time limit required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
